// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: data width, NOP encoding
// and fetch FSM state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [XLEN-1:0] PC_STEP = 32'h0000_0004;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble, hold keeps contents,
// load captures a fetched instruction; with none asserted a bubble enters.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q,   pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;

  // Flush beats hold beats load.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (hold_i) begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
    end else if (load_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end else begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM and next-PC priority logic
// feeding the IF/ID register. IF_MISALIGN_CHECK_EN enables the misaligned
// redirect trap (HALT state and fetch_misalign flag).
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst,
`ifdef IF_MISALIGN_CHECK_EN
  output logic            if_id_valid,
  output logic            fetch_misalign
`else
  output logic            if_id_valid
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_c, hold_c, load_c;
`ifdef IF_MISALIGN_CHECK_EN
  logic            misalign_q, misalign_d;
`endif

  // Next state, next PC and IF/ID control; redirect > stall > imem wait > fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_c = 1'b0;
    hold_c  = 1'b0;
    load_c  = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      BOOT: begin
        flush_c = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          flush_c = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
          if (branch_target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d = word_align(branch_target);
          end
`else
          pc_d = word_align(branch_target);
`endif
        end else if (stall) begin
          hold_c = 1'b1;
        end else if (!imem_valid) begin
          flush_c = 1'b1;
        end else begin
          load_c = 1'b1;
          pc_d   = pc_q + PC_STEP;
        end
      end
      default: begin
        flush_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q;
`endif

  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_c),
    .hold_i  (hold_c),
    .load_i  (load_c),
    .pc_i    (pc_q),
    .inst_i  (imem_rdata),
    .pc_o    (if_id_pc),
    .inst_o  (if_id_inst),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: reset, fetch, imem wait, stall, redirect,
// PC wrap, misaligned redirect and asynchronous reset.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst),
`ifdef IF_MISALIGN_CHECK_EN
    .if_id_valid   (if_id_valid),
    .fetch_misalign(fetch_misalign)
`else
    .if_id_valid   (if_id_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: address 0 holds addi x1,x0,5; others hold 0xA5 + addr[23:0].
  assign imem_rdata = (imem_addr == 32'h0) ? 32'h0050_0093 : {8'hA5, imem_addr[23:0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] inst, input logic valid);
    check({tag, "_pc"},    if_id_pc,           pc);
    check({tag, "_inst"},  if_id_inst,         inst);
    check({tag, "_valid"}, 32'(if_id_valid),   32'(valid));
  endtask

  initial begin
    rst = 1'b1; imem_valid = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    tick(); tick();
    check("rst_addr", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h13, 1'b0);
`ifdef IF_MISALIGN_CHECK_EN
    check("rst_misalign", 32'(fetch_misalign), 32'h0);
`endif
    rst = 1'b0;

    // BOOT edge ignores redirect/stall
    branch_taken = 1'b1; branch_target = 32'h100; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("boot_addr", imem_addr, 32'h0);
    check("boot_valid", 32'(if_id_valid), 32'h0);

    tick();
    check_ifid("first", 32'h0, 32'h0050_0093, 1'b1);
    check("first_addr", imem_addr, 32'h4);

    tick();
    check_ifid("second", 32'h4, 32'hA500_0004, 1'b1);
    check("second_addr", imem_addr, 32'h8);

    // imem wait for 3 cycles at pc=0x8
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ifid("wait", 32'h0, 32'h13, 1'b0);
      check("wait_addr", imem_addr, 32'h8);
    end
    imem_valid = 1'b1;
    tick();
    check_ifid("after_wait", 32'h8, 32'hA500_0008, 1'b1);
    check("after_wait_addr", imem_addr, 32'hC);

    tick();
    check("pre_stall_addr", imem_addr, 32'h10);

    // stall 2 cycles at pc=0x10
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_addr", imem_addr, 32'h10);
      check_ifid("stall", 32'hC, 32'hA500_000C, 1'b1);
    end
    stall = 1'b0;
    tick();
    check_ifid("post_stall", 32'h10, 32'hA500_0010, 1'b1);
    check("post_stall_addr", imem_addr, 32'h14);

    // redirect beats stall
    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("br_addr", imem_addr, 32'h40);
    check_ifid("br", 32'h0, 32'h13, 1'b0);
    tick();
    check_ifid("br_tgt", 32'h40, 32'hA500_0040, 1'b1);
    check("br_tgt_addr", imem_addr, 32'h44);

    // redirect to top of address space, then wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_valid", 32'(if_id_valid), 32'h0);
    tick();
    check_ifid("top_fetch", 32'hFFFF_FFFC, 32'hA5FF_FFFC, 1'b1);
    check("wrap_addr", imem_addr, 32'h0);

    // misaligned redirect
    branch_taken = 1'b1; branch_target = 32'h42;
    tick();
    branch_taken = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    check("mis_flag", 32'(fetch_misalign), 32'h1);
    check("mis_addr", imem_addr, 32'h0);
    check("mis_valid", 32'(if_id_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_flag", 32'(fetch_misalign), 32'h1);
      check("halt_addr", imem_addr, 32'h0);
      check("halt_valid", 32'(if_id_valid), 32'h0);
    end
`else
    check("mis_addr", imem_addr, 32'h40);
    check("mis_valid", 32'(if_id_valid), 32'h0);
    tick();
    check_ifid("mis_fetch", 32'h40, 32'hA500_0040, 1'b1);
    check("mis_next_addr", imem_addr, 32'h44);
`endif

    // asynchronous reset mid-operation
    #1 rst = 1'b1;
    #1;
    check("arst_addr", imem_addr, 32'h0);
    check_ifid("arst", 32'h0, 32'h13, 1'b0);
`ifdef IF_MISALIGN_CHECK_EN
    check("arst_misalign", 32'(fetch_misalign), 32'h0);
`endif
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_ifid("rerun", 32'h0, 32'h0050_0093, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 32-bit pipelined RISC-V core: owns the program counter, drives the instruction-memory address, and registers fetched instructions into the IF/ID pipeline register consumed by the decode stage (register file read, immediate generation, control). It honours load-use stalls from the hazard unit and branch redirects from EX/MEM, and inserts NOP bubbles on flushes and memory wait cycles.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset; must be word-aligned
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  32  fetch address; combinationally equals the PC register
- imem_rdata  in  32  instruction word at imem_addr
- imem_valid  in  1  imem_rdata valid this cycle
- stall  in  1  hold PC and IF/ID (load-use hazard)
- branch_taken  in  1  redirect fetch to branch_target, flush IF/ID
- branch_target  in  32  redirect address
- if_id_pc  out  32  PC of instruction held in IF/ID
- if_id_inst  out  32  instruction held in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_misalign  out  1  sticky misaligned-redirect flag (present only with macro, see Configuration)

## Operation
- FSM states: BOOT, RUN, HALT (HALT reachable only with macro).
- Reset: state=BOOT, pc=RESET_PC, if_id_pc=0, if_id_inst=NOP (32'h0000_0013), if_id_valid=0, fetch_misalign=0.
- BOOT: one cycle; no fetch accepted, IF/ID stays a bubble; next state RUN unconditionally (branch_taken/stall ignored).
- RUN, per edge, priority highest first:
  - branch_taken: pc<=branch_target; IF/ID<=bubble (inst=NOP, valid=0, pc=0). Wins over stall and imem_valid.
  - stall: pc and all IF/ID fields hold.
  - !imem_valid: pc holds; IF/ID<=bubble.
  - otherwise: if_id_pc<=pc, if_id_inst<=imem_rdata, if_id_valid<=1, pc<=pc+4.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), no flag.
- HALT: pc, IF/ID bubble held; exit only via rst.

## Timing
- imem_addr tracks pc with zero latency; imem_rdata sampled same cycle.
- Fetch latency: instruction at address A appears on if_id_inst one edge after pc==A with imem_valid=1 and no stall/redirect.
- After rst release: edge 1 BOOT->RUN; edge 2 latches first instruction (RESET_PC).
- Redirect: edge with branch_taken -> next cycle imem_addr=branch_target, if_id_valid=0; target instruction in IF/ID one edge later.
- Stall is level-sensitive; asserted N cycles holds exactly N cycles.
- rst asserted mid-operation returns all state to reset values immediately (asynchronous).

## Configuration
- IF_MISALIGN_CHECK_EN defined: in RUN, branch_taken with branch_target[1:0]!=0 -> pc unchanged, IF/ID<=bubble, fetch_misalign<=1 (sticky), state<=HALT. fetch_misalign port exists.
- Undefined: no HALT state, no fetch_misalign port; pc<={branch_target[31:2],2'b00} on every redirect.

## Structure
- Shared package riscv_pkg: NOP_INST constant (32'h0000_0013), fetch_state_t enum (BOOT, RUN, HALT), XLEN=32.
- One sub-module: if_id_reg (IF/ID register with hold and flush inputs, valid bit); if_stage holds PC, FSM, next-PC priority logic.

## Test plan
- Reset release, imem_valid=1, imem_rdata=0x0050_0093 at 0 -> edge 2: if_id_inst=0x0050_0093, if_id_pc=0, if_id_valid=1, imem_addr=4.
- stall=1 for 2 cycles mid-stream at pc=0x10 -> imem_addr stays 0x10, IF/ID unchanged both cycles, resumes 0x14 after.
- branch_taken=1 and stall=1 same cycle, target 0x40 -> next cycle imem_addr=0x40, if_id_inst=0x13, if_id_valid=0.
- imem_valid=0 for 3 cycles at pc=0x8 -> 3 bubbles (valid=0), pc holds 0x8, then normal fetch of 0x8.
- Redirect to 0xFFFF_FFFC, normal fetch -> imem_addr wraps to 0x0000_0000.
- Redirect to 0x42: with IF_MISALIGN_CHECK_EN -> fetch_misalign=1, if_id_valid=0 until rst; without -> imem_addr=0x40, fetch continues.
